// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the L2 arbitration slice.
//   - Requestor index constants for the L2 port clients.
//   - Line and address widths used on every L2-facing bus.
//   - arb_state_e, the arbiter FSM encoding.
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int REQ_ICACHE   = 0;
    localparam int REQ_DCACHE   = 1;
    localparam int REQ_IOMMU    = 2;
    localparam int REQ_PREFETCH = 3;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Searches req_valid starting at rr_ptr
// and wrapping around; the first active requestor found wins.
// Ports:
//   req_valid  [NUM_REQ]  active requests
//   rr_ptr     [PTR_W]    index with highest priority this round
//   winner     [NUM_REQ]  one-hot winner, all zero when nothing is requested
//   winner_idx [PTR_W]    binary index of the winner (0 when none)
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   winner_idx
);

    logic [PTR_W-1:0] idx;

    // Walk priority offsets from lowest to highest priority so that the last
    // hit, which is the one closest to rr_ptr, is what remains.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        idx        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (req_valid[idx]) begin
                winner      = '0;
                winner[idx] = 1'b1;
                winner_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// -----------------------------------------------------------------------------
// l2_arbiter
// Shares one L2 cache port among NUM_REQ requestors (icache, dcache, iommu,
// prefetcher) using round-robin arbitration. One transaction is outstanding
// at a time; the winning request is latched into the l2_* registers and held
// until l2_done, after which the requestor receives a one-cycle resp_done.
// At least one idle (bubble) cycle separates consecutive transactions.
//
// Optional feature: define L2_ARB_TIMEOUT_EN to abort a transaction that has
// waited TIMEOUT_CYCLES BUSY cycles without l2_done; it then completes with
// resp_error=1. Without the macro resp_error is tied low and BUSY waits forever.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   req_valid        [NUM_REQ]         request, held until resp_done
//   req_addr         [NUM_REQ*32]      per-requestor line address (flattened)
//   req_write_en     [NUM_REQ]         per-requestor write flag
//   req_write_data   [NUM_REQ*256]     per-requestor write line (flattened)
//   grant            [NUM_REQ]         one-hot owner of the L2 port, or zero
//   resp_data        [256]             registered L2 read line
//   resp_done        [NUM_REQ]         one-cycle completion pulse
//   resp_error                         resp_done qualifier: timed out
//   l2_addr/l2_request/l2_write_en/l2_write_data   request to l2_cache
//   l2_data/l2_done                    response from l2_cache
// -----------------------------------------------------------------------------
module l2_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_write_en,
    input  logic [NUM_REQ*LINE_W-1:0] req_write_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [LINE_W-1:0]         resp_data,
    output logic [NUM_REQ-1:0]        resp_done,
    output logic                      resp_error,
    output logic [ADDR_W-1:0]         l2_addr,
    output logic                      l2_request,
    output logic                      l2_write_en,
    output logic [LINE_W-1:0]         l2_write_data,
    input  logic [LINE_W-1:0]         l2_data,
    input  logic                      l2_done
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e       state;
    arb_state_e       state_next;
    logic             start;
    logic             finish;
    logic             timeout_hit;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   winner_idx;
    logic [NUM_REQ-1:0] pick;
    logic [PTR_W-1:0]   pick_idx;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req_valid  (req_valid),
        .rr_ptr     (rr_ptr),
        .winner     (pick),
        .winner_idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration only happens from IDLE, so the cycle after any completion
    // is always a bubble even if requests are pending.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    start      = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (l2_done || timeout_hit) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr        <= '0;
            winner_idx    <= '0;
            grant         <= '0;
            resp_done     <= '0;
            resp_data     <= '0;
            l2_request    <= 1'b0;
            l2_write_en   <= 1'b0;
            l2_addr       <= '0;
            l2_write_data <= '0;
        end else begin
            resp_done <= '0;
            if (start) begin
                grant         <= pick;
                winner_idx    <= pick_idx;
                l2_request    <= 1'b1;
                l2_addr       <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                l2_write_en   <= req_write_en[pick_idx];
                l2_write_data <= req_write_data[int'(pick_idx)*LINE_W +: LINE_W];
            end
            if (finish) begin
                grant                 <= '0;
                l2_request            <= 1'b0;
                resp_done[winner_idx] <= 1'b1;
                rr_ptr <= (winner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : winner_idx + 1'b1;
                // A timed-out transaction has no valid line to return.
                if (l2_done) begin
                    resp_data <= l2_data;
                end
            end
        end
    end

`ifdef L2_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (start) begin
            tmo_cnt <= '0;
        end else if (state == BUSY) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // tmo_cnt counts completed BUSY cycles, so TIMEOUT_CYCLES-1 marks the
    // last allowed cycle; l2_done arriving in that cycle still wins.
    assign timeout_hit = (state == BUSY) && !l2_done &&
                         (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_error <= 1'b0;
        end else begin
            resp_error <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign resp_error  = 1'b0;
`endif

endmodule

// File: tb/tb_l2_arbiter.sv
module tb_l2_arbiter;
    import mem_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      reset = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_write_en = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LINE_W-1:0] req_write_data;
    logic [NUM_REQ-1:0]        grant;
    logic [LINE_W-1:0]         resp_data;
    logic [NUM_REQ-1:0]        resp_done;
    logic                      resp_error;
    logic [ADDR_W-1:0]         l2_addr;
    logic                      l2_request;
    logic                      l2_write_en;
    logic [LINE_W-1:0]         l2_write_data;
    logic [LINE_W-1:0]         l2_data = '0;
    logic                      l2_done = 1'b0;

    logic [ADDR_W-1:0] r_addr  [NUM_REQ];
    logic [LINE_W-1:0] r_wdata [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign req_addr[g*ADDR_W +: ADDR_W]       = r_addr[g];
        assign req_write_data[g*LINE_W +: LINE_W] = r_wdata[g];
    end

    l2_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_write_en   (req_write_en),
        .req_write_data (req_write_data),
        .grant          (grant),
        .resp_data      (resp_data),
        .resp_done      (resp_done),
        .resp_error     (resp_error),
        .l2_addr        (l2_addr),
        .l2_request     (l2_request),
        .l2_write_en    (l2_write_en),
        .l2_write_data  (l2_write_data),
        .l2_data        (l2_data),
        .l2_done        (l2_done)
    );

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string tag, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Transaction-level reference: one owner at a time, round-robin from ptr.
    bit                m_busy  = 0;
    int                m_owner = 0;
    int                m_ptr   = 0;
    int                m_wait  = 0;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic              m_we    = 1'b0;
    logic [LINE_W-1:0] m_wdata = '0;
    logic [LINE_W-1:0] m_rdata = '0;
    logic [NUM_REQ-1:0] m_done = '0;
    logic              m_err   = 1'b0;

    // Stimulus state
    bit   rand_mode = 0;
    bit   hold_mode = 0;
    int   resp_lat  = 1;
    int   cur_lat   = 1;
    int   busy_cnt  = 0;
    int   busy_obs  = 0;
    logic [LINE_W-1:0] fixed_data = '0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic              last_we = 1'b0;
    logic [LINE_W-1:0] last_wdata = '0;
    logic [NUM_REQ-1:0] prev_grant = '0;
    int   skips [NUM_REQ];
    int   grant_q [$];

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_step();
        bit found;
        m_done = '0;
        m_err  = 1'b0;
        if (reset) begin
            m_busy  = 0;
            m_ptr   = 0;
            m_rdata = '0;
        end else if (!m_busy) begin
            found = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                int c;
                c = (m_ptr + k) % NUM_REQ;
                if (!found && req_valid[c]) begin
                    found   = 1;
                    m_owner = c;
                end
            end
            if (found) begin
                m_busy  = 1;
                m_wait  = 0;
                m_addr  = r_addr[m_owner];
                m_we    = req_write_en[m_owner];
                m_wdata = r_wdata[m_owner];
            end
        end else begin
            m_wait++;
            if (l2_done) begin
                m_busy  = 0;
                m_done  = NUM_REQ'(1) << m_owner;
                m_rdata = l2_data;
                m_ptr   = (m_owner + 1) % NUM_REQ;
            end
`ifdef L2_ARB_TIMEOUT_EN
            else if (m_wait == TIMEOUT) begin
                m_busy = 0;
                m_done = NUM_REQ'(1) << m_owner;
                m_err  = 1'b1;
                m_ptr  = (m_owner + 1) % NUM_REQ;
            end
`endif
        end
    endtask

    task automatic step();
        int g;
        @(posedge clk);
        #1;
        model_step();
        check("grant", grant, m_busy ? (NUM_REQ'(1) << m_owner) : '0);
        check("l2_request", l2_request, m_busy);
        check("resp_done", resp_done, m_done);
        check("resp_error", resp_error, m_err);
        check("resp_data", resp_data, m_rdata);
        if (m_busy) begin
            check("l2_addr", l2_addr, m_addr);
            check("l2_write_en", l2_write_en, m_we);
            check("l2_write_data", l2_write_data, m_wdata);
        end

        if (l2_request) begin
            busy_obs++;
            last_addr  = l2_addr;
            last_we    = l2_write_en;
            last_wdata = l2_write_data;
        end

        // Fairness from observed grants: a waiting requestor may be passed
        // over by at most NUM_REQ-1 other transactions.
        if (grant != 0 && prev_grant == 0) begin
            g = 0;
            for (int k = 0; k < NUM_REQ; k++) if (grant[k]) g = k;
            grant_q.push_back(g);
            check("fairness", skips[g] <= NUM_REQ - 1, 1'b1);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (k == g) skips[k] = 0;
                else if (req_valid[k]) skips[k]++;
            end
        end
        prev_grant = grant;
        for (int k = 0; k < NUM_REQ; k++) if (!req_valid[k]) skips[k] = 0;

        // L2 responder
        if (l2_request) busy_cnt++;
        else busy_cnt = 0;
        if (busy_cnt == 1) cur_lat = rand_mode ? int'($urandom_range(0, 4)) : resp_lat;
        l2_done = 1'b0;
        if (l2_request) begin
            if (cur_lat >= 0 && busy_cnt == cur_lat + 1) begin
                l2_done = 1'b1;
                l2_data = rand_mode ? rand_line() : fixed_data;
            end
        end else if (rand_mode && $urandom_range(0, 5) == 0) begin
            l2_done = 1'b1;
            l2_data = rand_line();
        end

        // Requestors
        for (int k = 0; k < NUM_REQ; k++) begin
            if (resp_done[k] && !hold_mode) begin
                req_valid[k] = 1'b0;
            end else if (rand_mode && !req_valid[k] && !resp_done[k] &&
                         $urandom_range(0, 2) == 0) begin
                r_addr[k]       = $urandom;
                req_write_en[k] = 1'($urandom_range(0, 1));
                r_wdata[k]      = rand_line();
                req_valid[k]    = 1'b1;
            end
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (resp_done == 0 && n < budget);
        check({tag, "_seen"}, resp_done != 0, 1'b1);
    endtask

    task automatic wait_grant(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (grant == 0 && n < budget);
        check({tag, "_grant_seen"}, grant != 0, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        for (int k = 0; k < NUM_REQ; k++) begin
            r_addr[k]  = '0;
            r_wdata[k] = '0;
            skips[k]   = 0;
        end

        // Reset state
        do_reset();
        check("rst_grant", grant, '0);
        check("rst_l2_request", l2_request, 1'b0);
        check("rst_l2_addr", l2_addr, '0);
        check("rst_l2_write_data", l2_write_data, '0);
        check("rst_resp_data", resp_data, '0);

        // Single icache read
        fixed_data = {32{8'hA5}};
        resp_lat   = 3;
        busy_obs   = 0;
        r_addr[REQ_ICACHE]       = 32'h100;
        req_write_en[REQ_ICACHE] = 1'b0;
        req_valid[REQ_ICACHE]    = 1'b1;
        wait_done("rd", 30);
        check("rd_done", resp_done, 4'b0001);
        check("rd_data", resp_data, {32{8'hA5}});
        check("rd_addr", last_addr, 32'h100);
        check("rd_busy_cycles", busy_obs, 4);
        step();

        // All four held valid from reset: strict rotation with bubbles
        do_reset();
        hold_mode = 1;
        resp_lat  = 1;
        for (int k = 0; k < NUM_REQ; k++) r_addr[k] = 32'h1000 * (k + 1);
        req_valid = '1;
        grant_q.delete();
        for (int n = 0; n < 60 && grant_q.size() < 5; n++) step();
        hold_mode = 0;
        req_valid = '0;
        for (int n = 0; n < 6; n++) step();
        check("rr_count", grant_q.size() >= 5, 1'b1);
        for (int k = 0; k < 5; k++)
            check($sformatf("rr_order%0d", k), (grant_q.size() > k) ? grant_q[k] : -1, exp_order[k]);

        // dcache write
        resp_lat = 2;
        r_addr[REQ_DCACHE]       = 32'h2000;
        r_wdata[REQ_DCACHE]      = 256'h1234;
        req_write_en[REQ_DCACHE] = 1'b1;
        req_valid[REQ_DCACHE]    = 1'b1;
        wait_done("wr", 30);
        check("wr_done", resp_done, 4'b0010);
        check("wr_addr", last_addr, 32'h2000);
        check("wr_we", last_we, 1'b1);
        check("wr_data", last_wdata, 256'h1234);
        step();

        // Winner drops req_valid mid-transaction
        resp_lat = 3;
        r_addr[REQ_PREFETCH]       = 32'h3040;
        req_write_en[REQ_PREFETCH] = 1'b0;
        req_valid[REQ_PREFETCH]    = 1'b1;
        wait_grant("drop", 10);
        req_valid[REQ_PREFETCH] = 1'b0;
        wait_done("drop", 30);
        check("drop_done", resp_done, 4'b1000);
        step();

        // Reset in the second BUSY cycle, then pointer back at requestor 0
        resp_lat = 1;
        req_valid[REQ_DCACHE] = 1'b1;
        wait_done("pre", 20);
        step();
        resp_lat = 20;
        req_valid[REQ_IOMMU] = 1'b1;
        wait_grant("rb", 10);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rb_l2_request", l2_request, 1'b0);
        check("rb_grant", grant, '0);
        check("rb_no_done", resp_done, '0);
        resp_lat = 1;
        req_valid[REQ_ICACHE] = 1'b1;
        step();
        check("rb_next_grant", grant, 4'b0001);
        wait_done("rb0", 20);
        step();
        wait_done("rb2", 20);
        step();

        // L2 never answers
        resp_lat = -1;
        busy_obs = 0;
        req_valid[REQ_IOMMU] = 1'b1;
`ifdef L2_ARB_TIMEOUT_EN
        wait_done("tmo", 40);
        check("tmo_done", resp_done, 4'b0100);
        check("tmo_error", resp_error, 1'b1);
        check("tmo_busy_cycles", busy_obs, TIMEOUT);
        step();
        check("tmo_error_pulse", resp_error, 1'b0);
`else
        for (int n = 0; n < 30; n++) step();
        check("hang_l2_request", l2_request, 1'b1);
        check("hang_grant", grant, 4'b0100);
        do_reset();
`endif

        // Randomized traffic
        do_reset();
        rand_mode = 1;
        for (int n = 0; n < 1500; n++) step();
        rand_mode = 0;
        resp_lat  = 1;
        for (int n = 0; n < 200 && (req_valid != 0 || l2_request); n++) step();
        check("drain_idle", {req_valid != 0, l2_request}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requestors: 0=icache, 1=dcache, 2=iommu, 3=prefetcher.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, L2 wait limit in cycles; used only when the timeout feature is compiled in.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, [NUM_REQ], per-requestor request, held high until that requestor's resp_done.
REQ-006 SHALL have port req_addr, input, [NUM_REQ][32], per-requestor physical line address.
REQ-007 SHALL have port req_write_en, input, [NUM_REQ], per-requestor write flag.
REQ-008 SHALL have port req_write_data, input, [NUM_REQ][256], per-requestor write line.
REQ-009 SHALL have port grant, output, [NUM_REQ], one-hot owner of the L2 port, or all zero.
REQ-010 SHALL have port resp_data, output, 256, registered L2 read line.
REQ-011 SHALL have port resp_done, output, [NUM_REQ], one-cycle completion pulse.
REQ-012 SHALL have port resp_error, output, 1, qualifies resp_done as timed out.
REQ-013 SHALL have port l2_addr, output, 32, address to l2_cache.
REQ-014 SHALL have port l2_request, output, 1, request to l2_cache.
REQ-015 SHALL have port l2_write_en, output, 1, write flag to l2_cache.
REQ-016 SHALL have port l2_write_data, output, 256, write line to l2_cache.
REQ-017 SHALL have port l2_data, input, 256, L2 read line.
REQ-018 SHALL have port l2_done, input, 1, L2 completion.

Function
REQ-019 SHALL implement FSM states IDLE and BUSY.
REQ-020 IDLE, any req_valid at cycle N: SHALL choose the winner round-robin starting at rr_ptr, latch its addr/write_en/write_data into l2_* registers, and enter BUSY; grant and l2_request SHALL be high from N+1.
REQ-021 BUSY: l2_request, grant and all l2_* outputs SHALL hold stable until the cycle l2_done is sampled high.
REQ-022 l2_done sampled in BUSY at cycle M: resp_data<=l2_data, resp_done[winner]=1 at M+1 for one cycle, l2_request and grant low at M+1, rr_ptr<=(winner+1) mod NUM_REQ, return to IDLE.
REQ-023 New arbitration SHALL NOT occur in the cycle l2_done is sampled; there SHALL be one bubble cycle minimum between transactions.
REQ-024 l2_done while IDLE SHALL be ignored.
REQ-025 Winner dropping req_valid during BUSY SHALL NOT abort the transaction; resp_done SHALL still pulse.
REQ-026 A write transaction SHALL complete with resp_done; resp_data is then don't-care but SHALL be loaded from l2_data.
REQ-027 A requestor holding req_valid SHALL be granted within NUM_REQ transactions (no starvation).

Reset
REQ-028 reset SHALL set FSM=IDLE, rr_ptr=0, grant=0, resp_done=0, resp_error=0, l2_request=0, l2_write_en=0, l2_addr=0, l2_write_data=0, resp_data=0.
REQ-029 reset asserted during BUSY SHALL abandon the transaction with no resp_done pulse.

Configuration
REQ-030 With macro L2_ARB_TIMEOUT_EN defined: a counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-031 With L2_ARB_TIMEOUT_EN defined: when the count reaches TIMEOUT_CYCLES without l2_done, the next cycle SHALL pulse resp_done[winner] with resp_error=1, drop l2_request, advance rr_ptr and enter IDLE.
REQ-032 With L2_ARB_TIMEOUT_EN defined: l2_done in that same cycle SHALL take precedence and complete normally.
REQ-033 Without L2_ARB_TIMEOUT_EN: BUSY SHALL wait indefinitely, resp_error SHALL be tied 0, and no counter logic SHALL exist.

Structure
REQ-034 Package mem_pkg SHALL hold the requestor index constants (REQ_ICACHE=0, REQ_DCACHE=1, REQ_IOMMU=2, REQ_PREFETCH=3), LINE_W=256, and the arb_state_e enum.
REQ-035 Sub-module rr_picker SHALL be combinational and map (req_valid, rr_ptr) to a one-hot winner.

Verification
REQ-036 Single read: req_valid[0]=1, addr 0x100; l2_done 3 cycles later with l2_data=0xA5..A5 -> l2_addr=0x100, resp_done[0] one cycle after l2_done, resp_data=0xA5..A5.
REQ-037 All four requestors valid from reset with l2_done 1 cycle after each l2_request -> grant order 0,1,2,3,0, with a bubble between each.
REQ-038 dcache write, addr 0x2000, data 0x1234: l2_write_en=1, l2_write_data=0x1234, l2_addr=0x2000 held until l2_done; resp_done[1] pulses.
REQ-039 reset in the 2nd BUSY cycle -> l2_request=0 and grant=0 next cycle, no resp_done, next grant goes to requestor 0.
REQ-040 With L2_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, l2_done never asserted -> resp_done[2]=1 with resp_error=1 after 8 BUSY cycles; without the macro, l2_request stays high.
